reorder_buffer: RTL and testbench

Circular in-order retirement queue between the decoder (issue), the ALU/LSB result buses (writeback) and the register file (commit). It allocates a ROB position per issued instruction and records each result as it arrives. It retires at most one instruction per cycle to the register file and LSB. On a branch mispredict at commit it flushes the whole machine.

---
 rtl/reorder_buffer.sv | 193 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates a slot per issued instruction,
// collects ALU/LSB results, retires one entry per cycle and flushes on mispredict.
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  output logic                 rob_full,
  input  logic                 issue,
  output logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_is_store,
  input  logic                 issue_is_branch,
  input  logic                 issue_pred_jump,
  input  logic [31:0]          issue_pc,
  input  logic                 issue_ready,
  input  logic [31:0]          issue_val,
  input  logic                 alu_valid,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  input  logic [31:0]          alu_val,
  input  logic                 alu_jump,
  input  logic [31:0]          alu_target,
  input  logic                 lsb_valid,
  input  logic [ROB_POS_W-1:0] lsb_rob_pos,
  input  logic [31:0]          lsb_val,
  input  logic [ROB_POS_W-1:0] q1_pos,
  input  logic [ROB_POS_W-1:0] q2_pos,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [31:0]          q1_val,
  output logic [31:0]          q2_val,
  output logic                 rob_commit,
  output logic [4:0]           rob_commit_rd,
  output logic [31:0]          rob_commit_val,
  output logic [ROB_POS_W-1:0] rob_commit_rob_pos,
  output logic                 commit_store,
  output logic [ROB_POS_W-1:0] commit_store_rob_pos,
  output logic                 rollback,
  output logic [31:0]          rollback_pc
);

  localparam logic [ROB_POS_W:0]   CNT_FULL   = (ROB_POS_W+1)'(ROB_SIZE);
  localparam logic [ROB_POS_W:0]   CNT_ALMOST = (ROB_POS_W+1)'(ROB_SIZE - 1);
  localparam logic [ROB_POS_W:0]   CNT_ONE    = (ROB_POS_W+1)'(1);
  localparam logic [ROB_POS_W-1:0] POS_ONE    = ROB_POS_W'(1);
  localparam logic [31:0]          PC_STEP    = 32'd4;

  logic [ROB_SIZE-1:0]  r_busy;
  logic [ROB_SIZE-1:0]  r_ready;
  logic [4:0]           r_rd        [ROB_SIZE];
  logic                 r_is_store  [ROB_SIZE];
  logic                 r_is_branch [ROB_SIZE];
  logic                 r_pred_jump [ROB_SIZE];
  logic                 r_real_jump [ROB_SIZE];
  logic [31:0]          r_pc        [ROB_SIZE];
  logic [31:0]          r_target    [ROB_SIZE];
  logic [31:0]          r_val       [ROB_SIZE];
  logic [ROB_POS_W-1:0] r_head;
  logic [ROB_POS_W-1:0] r_tail;
  logic [ROB_POS_W:0]   r_count;

  logic w_commit;
  logic w_mispredict;
  logic w_issue_ok;
  logic w_alu_wb;
  logic w_lsb_wb;

  // Commit decision looks only at registered state, never at this cycle's buses.
  assign w_commit     = r_busy[r_head] && r_ready[r_head];
  assign w_mispredict = w_commit && r_is_branch[r_head] &&
                        (r_real_jump[r_head] != r_pred_jump[r_head]);
  assign w_issue_ok   = issue && !w_mispredict && (r_count != CNT_FULL);
  assign w_alu_wb     = alu_valid && r_busy[alu_rob_pos] && !w_mispredict;
  assign w_lsb_wb     = lsb_valid && r_busy[lsb_rob_pos] && !w_mispredict;

  assign rob_full      = (r_count >= CNT_ALMOST);
  assign issue_rob_pos = r_tail;

  // Operand lookup: a same-cycle bus hit beats the stored entry.
  always_comb begin
    q1_ready = r_ready[q1_pos];
    q1_val   = r_val[q1_pos];
    if (alu_valid && (alu_rob_pos == q1_pos)) begin
      q1_ready = 1'b1;
      q1_val   = alu_val;
    end else if (lsb_valid && (lsb_rob_pos == q1_pos)) begin
      q1_ready = 1'b1;
      q1_val   = lsb_val;
    end
  end

  always_comb begin
    q2_ready = r_ready[q2_pos];
    q2_val   = r_val[q2_pos];
    if (alu_valid && (alu_rob_pos == q2_pos)) begin
      q2_ready = 1'b1;
      q2_val   = alu_val;
    end else if (lsb_valid && (lsb_rob_pos == q2_pos)) begin
      q2_ready = 1'b1;
      q2_val   = lsb_val;
    end
  end

  // Control state and registered retirement outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy               <= '0;
      r_ready              <= '0;
      r_head               <= '0;
      r_tail               <= '0;
      r_count              <= '0;
      rob_commit           <= 1'b0;
      rob_commit_rd        <= '0;
      rob_commit_val       <= '0;
      rob_commit_rob_pos   <= '0;
      commit_store         <= 1'b0;
      commit_store_rob_pos <= '0;
      rollback             <= 1'b0;
      rollback_pc          <= '0;
    end else if (!rdy) begin
      rob_commit   <= 1'b0;
      commit_store <= 1'b0;
      rollback     <= 1'b0;
    end else begin
      rob_commit   <= 1'b0;
      commit_store <= 1'b0;
      rollback     <= 1'b0;
      if (w_commit) begin
        rob_commit         <= 1'b1;
        rob_commit_rd      <= r_is_store[r_head] ? 5'd0 : r_rd[r_head];
        rob_commit_val     <= r_val[r_head];
        rob_commit_rob_pos <= r_head;
        if (r_is_store[r_head]) begin
          commit_store         <= 1'b1;
          commit_store_rob_pos <= r_head;
        end
      end
      if (w_mispredict) begin
        rollback    <= 1'b1;
        rollback_pc <= r_real_jump[r_head] ? r_target[r_head]
                                           : (r_pc[r_head] + PC_STEP);
        r_busy      <= '0;
        r_ready     <= '0;
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
      end else begin
        if (w_alu_wb) r_ready[alu_rob_pos] <= 1'b1;
        if (w_lsb_wb) r_ready[lsb_rob_pos] <= 1'b1;
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + POS_ONE;
        end
        if (w_issue_ok) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= issue_ready;
          r_tail          <= r_tail + POS_ONE;
        end
        case ({w_issue_ok, w_commit})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload; validity is tracked by r_busy/r_ready so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (w_alu_wb) begin
        r_val[alu_rob_pos]       <= alu_val;
        r_real_jump[alu_rob_pos] <= alu_jump;
        r_target[alu_rob_pos]    <= alu_target;
      end
      if (w_lsb_wb) r_val[lsb_rob_pos] <= lsb_val;
      if (w_issue_ok) begin
        r_rd[r_tail]        <= issue_rd;
        r_is_store[r_tail]  <= issue_is_store;
        r_is_branch[r_tail] <= issue_is_branch;
        r_pred_jump[r_tail] <= issue_pred_jump;
        r_pc[r_tail]        <= issue_pc;
        r_val[r_tail]       <= issue_val;
      end
    end
  end

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    !(rdy && issue && (r_count == CNT_FULL)));

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: one task per scenario, inline checks.
module tb_reorder_buffer;
  logic        clk, rst, rdy;
  logic        rob_full, issue;
  logic [3:0]  issue_rob_pos;
  logic [4:0]  issue_rd;
  logic        issue_is_store, issue_is_branch, issue_pred_jump, issue_ready;
  logic [31:0] issue_pc, issue_val;
  logic        alu_valid, alu_jump;
  logic [3:0]  alu_rob_pos;
  logic [31:0] alu_val, alu_target;
  logic        lsb_valid;
  logic [3:0]  lsb_rob_pos;
  logic [31:0] lsb_val;
  logic [3:0]  q1_pos, q2_pos;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        rob_commit;
  logic [4:0]  rob_commit_rd;
  logic [31:0] rob_commit_val;
  logic [3:0]  rob_commit_rob_pos;
  logic        commit_store;
  logic [3:0]  commit_store_rob_pos;
  logic        rollback;
  logic [31:0] rollback_pc;

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer #(.ROB_SIZE(16), .ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_full(rob_full),
    .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_rd(issue_rd),
    .issue_is_store(issue_is_store), .issue_is_branch(issue_is_branch),
    .issue_pred_jump(issue_pred_jump), .issue_pc(issue_pc),
    .issue_ready(issue_ready), .issue_val(issue_val),
    .alu_valid(alu_valid), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
    .alu_jump(alu_jump), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
    .q1_pos(q1_pos), .q2_pos(q2_pos), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .rob_commit(rob_commit), .rob_commit_rd(rob_commit_rd),
    .rob_commit_val(rob_commit_val), .rob_commit_rob_pos(rob_commit_rob_pos),
    .commit_store(commit_store), .commit_store_rob_pos(commit_store_rob_pos),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue = 0; issue_rd = 0; issue_is_store = 0; issue_is_branch = 0;
    issue_pred_jump = 0; issue_pc = 0; issue_ready = 0; issue_val = 0;
    alu_valid = 0; alu_rob_pos = 0; alu_val = 0; alu_jump = 0; alu_target = 0;
    lsb_valid = 0; lsb_rob_pos = 0; lsb_val = 0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic st, input logic br,
                          input logic pj, input logic [31:0] pc,
                          input logic rd_y, input logic [31:0] v);
    idle();
    issue = 1; issue_rd = rd; issue_is_store = st; issue_is_branch = br;
    issue_pred_jump = pj; issue_pc = pc; issue_ready = rd_y; issue_val = v;
  endtask

  task automatic apply_reset();
    idle(); rdy = 1; rst = 1; q1_pos = 0; q2_pos = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (rob_commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", rob_commit); end
    n_tests++; if (rollback !== 1'b0 || rollback_pc !== 32'h0) begin n_fail++; $display("FAIL reset_rollback: got %b/%h want 0/0", rollback, rollback_pc); end
    n_tests++; if (commit_store !== 1'b0 || rob_commit_val !== 32'h0 || rob_commit_rd !== 5'd0) begin n_fail++; $display("FAIL reset_outs: store %b val %h rd %0d want zeros", commit_store, rob_commit_val, rob_commit_rd); end
    n_tests++; if (rob_full !== 1'b0 || issue_rob_pos !== 4'd0) begin n_fail++; $display("FAIL reset_tail: full %b pos %0d want 0/0", rob_full, issue_rob_pos); end
    q1_pos = 0; #1;
    n_tests++; if (q1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_q1: got %b want 0", q1_ready); end
  endtask

  task automatic test_basic_commit();
    apply_reset();
    do_issue(5'd5, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    n_tests++; if (issue_rob_pos !== 4'd1) begin n_fail++; $display("FAIL basic_tail: got %0d want 1", issue_rob_pos); end
    idle(); alu_valid = 1; alu_rob_pos = 0; alu_val = 32'h1234; tick();
    n_tests++; if (rob_commit !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", rob_commit); end
    idle(); tick();
    n_tests++; if (rob_commit !== 1'b1 || rob_commit_rd !== 5'd5 || rob_commit_val !== 32'h1234 || rob_commit_rob_pos !== 4'd0)
      begin n_fail++; $display("FAIL basic_commit: got %b rd %0d val %h pos %0d want 1 rd 5 val 1234 pos 0", rob_commit, rob_commit_rd, rob_commit_val, rob_commit_rob_pos); end
    n_tests++; if (dut.r_count !== 5'd0) begin n_fail++; $display("FAIL basic_count: got %0d want 0", dut.r_count); end
    tick();
    n_tests++; if (rob_commit !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b want 0", rob_commit); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 14; i++) begin do_issue(5'd1, 0, 0, 0, 32'h0, 0, 32'h0); tick(); end
    n_tests++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL full_at14: got %b want 0", rob_full); end
    do_issue(5'd1, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    n_tests++; if (rob_full !== 1'b1 || issue_rob_pos !== 4'd15) begin n_fail++; $display("FAIL full_at15: full %b pos %0d want 1/15", rob_full, issue_rob_pos); end
    do_issue(5'd1, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    idle();
    n_tests++; if (issue_rob_pos !== 4'd0 || dut.r_head !== 4'd0 || dut.r_count !== 5'd16)
      begin n_fail++; $display("FAIL full_wrap: tail %0d head %0d count %0d want 0/0/16", issue_rob_pos, dut.r_head, dut.r_count); end
    n_tests++; if (rob_commit !== 1'b0) begin n_fail++; $display("FAIL full_nocommit: got %b want 0", rob_commit); end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    do_issue(5'd1, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    do_issue(5'd2, 0, 0, 0, 32'h4, 0, 32'h0); tick();
    idle(); alu_valid = 1; alu_rob_pos = 1; alu_val = 32'h11; tick();
    n_tests++; if (rob_commit !== 1'b0) begin n_fail++; $display("FAIL ooo_hold1: got %b want 0", rob_commit); end
    idle(); alu_valid = 1; alu_rob_pos = 0; alu_val = 32'h22; tick();
    n_tests++; if (rob_commit !== 1'b0) begin n_fail++; $display("FAIL ooo_hold0: got %b want 0", rob_commit); end
    idle(); tick();
    n_tests++; if (rob_commit !== 1'b1 || rob_commit_rob_pos !== 4'd0 || rob_commit_val !== 32'h22 || rob_commit_rd !== 5'd1)
      begin n_fail++; $display("FAIL ooo_first: got %b pos %0d val %h rd %0d want 1 pos 0 val 22 rd 1", rob_commit, rob_commit_rob_pos, rob_commit_val, rob_commit_rd); end
    tick();
    n_tests++; if (rob_commit !== 1'b1 || rob_commit_rob_pos !== 4'd1 || rob_commit_val !== 32'h11 || rob_commit_rd !== 5'd2)
      begin n_fail++; $display("FAIL ooo_second: got %b pos %0d val %h rd %0d want 1 pos 1 val 11 rd 2", rob_commit, rob_commit_rob_pos, rob_commit_val, rob_commit_rd); end
    tick();
    n_tests++; if (rob_commit !== 1'b0) begin n_fail++; $display("FAIL ooo_done: got %b want 0", rob_commit); end
  endtask

  task automatic test_store();
    apply_reset();
    do_issue(5'd7, 1, 0, 0, 32'h40, 0, 32'h0); tick();
    idle(); lsb_valid = 1; lsb_rob_pos = 0; lsb_val = 32'h55; tick();
    idle(); tick();
    n_tests++; if (rob_commit !== 1'b1 || commit_store !== 1'b1 || rob_commit_rd !== 5'd0)
      begin n_fail++; $display("FAIL store_commit: commit %b store %b rd %0d want 1/1/0", rob_commit, commit_store, rob_commit_rd); end
    n_tests++; if (commit_store_rob_pos !== 4'd0 || rob_commit_rob_pos !== 4'd0)
      begin n_fail++; $display("FAIL store_pos: got %0d/%0d want 0/0", commit_store_rob_pos, rob_commit_rob_pos); end
    tick();
    n_tests++; if (commit_store !== 1'b0) begin n_fail++; $display("FAIL store_pulse: got %b want 0", commit_store); end
  endtask

  task automatic test_rollback();
    apply_reset();
    do_issue(5'd0, 0, 1, 0, 32'h100, 0, 32'h0); tick();
    idle(); alu_valid = 1; alu_rob_pos = 0; alu_jump = 1; alu_target = 32'h200; tick();
    do_issue(5'd3, 0, 0, 0, 32'h104, 1, 32'h77); tick();
    idle();
    n_tests++; if (rollback !== 1'b1 || rob_commit !== 1'b1 || rollback_pc !== 32'h200)
      begin n_fail++; $display("FAIL rb_taken: rb %b commit %b pc %h want 1/1/200", rollback, rob_commit, rollback_pc); end
    n_tests++; if (dut.r_count !== 5'd0 || issue_rob_pos !== 4'd0)
      begin n_fail++; $display("FAIL rb_clear: count %0d tail %0d want 0/0", dut.r_count, issue_rob_pos); end
    q1_pos = 0; q2_pos = 1; #1;
    n_tests++; if (q1_ready !== 1'b0 || q2_ready !== 1'b0) begin n_fail++; $display("FAIL rb_query: got %b/%b want 0/0", q1_ready, q2_ready); end
    tick();
    n_tests++; if (rollback !== 1'b0 || rob_commit !== 1'b0) begin n_fail++; $display("FAIL rb_pulse: rb %b commit %b want 0/0", rollback, rob_commit); end
    do_issue(5'd0, 0, 1, 1, 32'h300, 0, 32'h0); tick();
    idle(); alu_valid = 1; alu_rob_pos = 0; alu_jump = 0; alu_target = 32'h999; tick();
    idle(); tick();
    n_tests++; if (rollback !== 1'b1 || rollback_pc !== 32'h304) begin n_fail++; $display("FAIL rb_nottaken: rb %b pc %h want 1/304", rollback, rollback_pc); end
    tick();
    do_issue(5'd1, 0, 1, 1, 32'h400, 0, 32'h0); tick();
    idle(); alu_valid = 1; alu_rob_pos = 0; alu_jump = 1; alu_target = 32'h500; alu_val = 32'h404; tick();
    idle(); tick();
    n_tests++; if (rollback !== 1'b0 || rob_commit !== 1'b1 || rob_commit_val !== 32'h404 || rob_commit_rd !== 5'd1)
      begin n_fail++; $display("FAIL br_correct: rb %b commit %b val %h rd %0d want 0/1/404/1", rollback, rob_commit, rob_commit_val, rob_commit_rd); end
  endtask

  task automatic test_bypass_and_count();
    apply_reset();
    do_issue(5'd4, 0, 0, 0, 32'h0, 1, 32'h9); tick();
    do_issue(5'd5, 0, 0, 0, 32'h4, 0, 32'h0); tick();
    n_tests++; if (rob_commit !== 1'b1 || rob_commit_val !== 32'h9 || dut.r_count !== 5'd1 || issue_rob_pos !== 4'd2)
      begin n_fail++; $display("FAIL both_count: commit %b val %h count %0d tail %0d want 1/9/1/2", rob_commit, rob_commit_val, dut.r_count, issue_rob_pos); end
    do_issue(5'd6, 0, 0, 0, 32'h8, 0, 32'h0); tick();
    do_issue(5'd7, 0, 0, 0, 32'hc, 0, 32'h0); tick();
    idle(); alu_valid = 1; alu_rob_pos = 3; alu_val = 32'h7; lsb_valid = 1; lsb_rob_pos = 2; lsb_val = 32'h8;
    q1_pos = 3; q2_pos = 2; #1;
    n_tests++; if (q1_ready !== 1'b1 || q1_val !== 32'h7) begin n_fail++; $display("FAIL byp_alu: got %b/%h want 1/7", q1_ready, q1_val); end
    n_tests++; if (q2_ready !== 1'b1 || q2_val !== 32'h8) begin n_fail++; $display("FAIL byp_lsb: got %b/%h want 1/8", q2_ready, q2_val); end
    tick();
    idle(); q1_pos = 3; q2_pos = 1; #1;
    n_tests++; if (q1_ready !== 1'b1 || q1_val !== 32'h7 || q2_ready !== 1'b0)
      begin n_fail++; $display("FAIL stored_q: q1 %b/%h q2 %b want 1/7 0", q1_ready, q1_val, q2_ready); end
    q2_pos = 2; #1;
    n_tests++; if (q2_ready !== 1'b1 || q2_val !== 32'h8) begin n_fail++; $display("FAIL stored_lsb: got %b/%h want 1/8", q2_ready, q2_val); end
    alu_valid = 1; alu_rob_pos = 9; alu_val = 32'hdead; tick();
    idle(); q1_pos = 9; #1;
    n_tests++; if (q1_ready !== 1'b0) begin n_fail++; $display("FAIL wb_notbusy: got %b want 0", q1_ready); end
  endtask

  task automatic test_rdy_freeze();
    apply_reset();
    do_issue(5'd2, 0, 0, 0, 32'h0, 1, 32'h33); rdy = 0; tick();
    n_tests++; if (issue_rob_pos !== 4'd0) begin n_fail++; $display("FAIL rdy_issue: tail %0d want 0", issue_rob_pos); end
    rdy = 1; tick();
    idle(); rdy = 0; tick(); tick();
    n_tests++; if (rob_commit !== 1'b0 || dut.r_count !== 5'd1) begin n_fail++; $display("FAIL rdy_hold: commit %b count %0d want 0/1", rob_commit, dut.r_count); end
    rdy = 1; tick();
    n_tests++; if (rob_commit !== 1'b1 || rob_commit_val !== 32'h33) begin n_fail++; $display("FAIL rdy_resume: commit %b val %h want 1/33", rob_commit, rob_commit_val); end
    do_issue(5'd3, 0, 0, 0, 32'h4, 0, 32'h0); tick(); tick();
    idle(); rdy = 0; rst = 1; tick();
    rst = 0; rdy = 1;
    n_tests++; if (dut.r_count !== 5'd0 || issue_rob_pos !== 4'd0) begin n_fail++; $display("FAIL rst_mid: count %0d tail %0d want 0/0", dut.r_count, issue_rob_pos); end
  endtask

  initial begin
    rst = 1; rdy = 1; idle(); q1_pos = 0; q2_pos = 0;
    test_reset();
    test_basic_commit();
    test_full_wrap();
    test_out_of_order();
    test_store();
    test_rollback();
    test_bypass_and_count();
    test_rdy_freeze();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
